decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, pipelined successor to the single-cycle R-type decoder.
- Decodes the RV32I/RV64I integer ALU groups: OP, OP-IMM, OP-32 and OP-IMM-32.
- Sits between fetch and the register-file/ALU stage, with a valid/ready handshake and a 2-entry skid buffer so backpressure never drops an instruction.
- Adds immediate generation, W-variant flagging, illegal-instruction detection and flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- ENABLE_W, 1, enables OP-32/OP-IMM-32 decode; forced to 0 when XLEN=32.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- instruction  in  32  raw instruction word.
- out_valid  out  1  decoded bundle present.
- out_ready  in  1  consumer accepts.
- rs1_addr, rs2_addr, rd_addr  out  5 each  register fields.
- opcode  out  7; fun3  out  3; fun7  out  7  raw fields.
- op_sel  out  10  one-hot {and,or,sra,srl,xor,sltu,slt,sll,sub,add}; bit0 = add.
- word_op  out  1  W-variant (32-bit result, sign-extended).
- use_imm  out  1  operand B is imm.
- imm  out  XLEN  sign-extended I-immediate, or zero-extended shamt.
- rf_we  out  1  register write enable.
- illegal  out  1  unsupported or malformed encoding.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, skid empty, all data outputs 0, in_ready=1 on the next cycle.
- Handshake:
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - Latency 1 cycle: input accepted at edge N appears at out_valid after edge N.
  - Throughput 1 per cycle while out_ready=1.
- Skid buffer:
  - in_ready = skid empty (registered, with no combinational path from out_ready).
  - If the output register is held (out_valid & !out_ready) and an input arrives, it goes to the skid entry.
  - When the output drains, the skid entry moves to the output register; the skid is empty again next cycle.
  - Order is strictly preserved.
  - Data outputs must stay stable while out_valid & !out_ready.
- Flush:
  - Has priority over everything except reset.
  - At the edge: out_valid=0, skid cleared, and any instruction transferring in the same cycle is discarded.
  - in_ready=1 the following cycle.
- Decode, OP (0110011):
  - fun7=0000000: fun3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - fun7=0100000: fun3 000 sub, 101 sra.
  - Any other fun7/fun3 combination is illegal.
- Decode, OP-IMM (0010011):
  - Same mapping as OP with use_imm=1; no sub.
  - Shifts, XLEN=64: instr[31:26] must be 000000 (sll/srl) or 010000 (sra, fun3=101); shamt=instr[25:20].
  - Shifts, XLEN=32: instr[31:25] must be 0000000 or 0100000; shamt=instr[24:20].
  - Any other high bits on a shift are illegal.
- Decode, OP-32 (0111011), when ENABLE_W:
  - Legal: addw, subw, sllw, srlw, sraw; word_op=1.
  - Any other fun3 is illegal.
- Decode, OP-IMM-32 (0011011), when ENABLE_W:
  - Legal: addiw, slliw, srliw, sraiw; shamt=instr[24:20], and instr[25] must be 0.
- W opcodes when !ENABLE_W: illegal.
- Illegal instruction:
  - op_sel=0, rf_we=0, word_op=0, use_imm=0, illegal=1.
  - Still handshaken through the pipeline; raw fields are still output.
- rd_addr=0: rf_we=0 and illegal=0.
- imm: I-type is instr[31:20] sign-extended to XLEN; shifts use the zero-extended shamt; R-type gives imm=0.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32;
  - FUN7_BASE=0000000, FUN7_ALT=0100000;
  - op_sel bit indices;
  - the decoded-bundle struct/width constant.
- One combinational sub-module, decode_logic, maps instruction to the bundle.
- decode_stage wraps it with the output register and skid buffer.

Test Plan:
- Back-to-back, out_ready=1, XLEN=64: 0x00b50c33, 0x40b50c33, 0x00b51c33, 0x00b52c33 -> each one cycle after acceptance: rs1=10, rs2=11, rd=24, op_sel = add, sub, sll, slt respectively (0x001, 0x002, 0x004, 0x008), rf_we=1, illegal=0.
- 0xfff10093 (addi x1,x2,-1) -> use_imm=1, imm=0xFFFF_FFFF_FFFF_FFFF, op_sel=0x001, rd=1; 0x43f55593 (srai x11,x10,63) -> op_sel=0x080 (sra), imm=63.
- 0x40b50c3b (subw): XLEN=64 -> op_sel=0x002, word_op=1; XLEN=32 -> illegal=1, op_sel=0, rf_we=0.
- Backpressure: hold out_ready=0 and present 3 instructions -> 2 accepted, in_ready=0 on the third. Release -> outputs in original order, no loss, third accepted the cycle after the skid frees.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed instruction ever appears.
- rst_n=0 mid-stream for one cycle -> out_valid=0 and all outputs 0 next cycle; 0x00b50033 (add x0) -> rf_we=0, illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared definitions for the integer decode stage: major
//                opcodes, fun7 encodings, op_sel bit positions and the
//                decoded-bundle structure passed from decode_logic to the
//                pipeline register in decode_stage.
//  Revision    : 1.0 - initial pipelined decode stage
// ============================================================================
package decode_pkg;

    // Major opcodes of the integer ALU groups
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // fun7 encodings
    localparam logic [6:0] FUN7_BASE = 7'b0000000;
    localparam logic [6:0] FUN7_ALT  = 7'b0100000;

    // op_sel one-hot bit positions {and,or,sra,srl,xor,sltu,slt,sll,sub,add}
    localparam int SEL_ADD  = 0;
    localparam int SEL_SUB  = 1;
    localparam int SEL_SLL  = 2;
    localparam int SEL_SLT  = 3;
    localparam int SEL_SLTU = 4;
    localparam int SEL_XOR  = 5;
    localparam int SEL_SRL  = 6;
    localparam int SEL_SRA  = 7;
    localparam int SEL_OR   = 8;
    localparam int SEL_AND  = 9;
    localparam int OP_SEL_W = 10;

    // The bundle always carries a 64-bit immediate; the top truncates to XLEN.
    localparam int IMM_W = 64;

    typedef struct packed {
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic [4:0]          rd_addr;
        logic [6:0]          opcode;
        logic [2:0]          fun3;
        logic [6:0]          fun7;
        logic [OP_SEL_W-1:0] op_sel;
        logic                word_op;
        logic                use_imm;
        logic [IMM_W-1:0]    imm;
        logic                rf_we;
        logic                illegal;
    } decoded_t;

    localparam int DECODED_W = $bits(decoded_t);

    // Operation selected by fun3 when fun7 holds the base encoding. Every
    // fun3 value maps to exactly one operation in that case.
    function automatic logic [OP_SEL_W-1:0] base_sel(input logic [2:0] f3);
        logic [OP_SEL_W-1:0] sel;
        sel = '0;
        case (f3)
            3'b000:  sel[SEL_ADD]  = 1'b1;
            3'b001:  sel[SEL_SLL]  = 1'b1;
            3'b010:  sel[SEL_SLT]  = 1'b1;
            3'b011:  sel[SEL_SLTU] = 1'b1;
            3'b100:  sel[SEL_XOR]  = 1'b1;
            3'b101:  sel[SEL_SRL]  = 1'b1;
            3'b110:  sel[SEL_OR]   = 1'b1;
            default: sel[SEL_AND]  = 1'b1;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// ============================================================================
//  Module      : decode_logic
//  Description : Purely combinational decoder for the OP, OP-IMM, OP-32 and
//                OP-IMM-32 groups. Produces register fields, one-hot ALU
//                select, immediate, W-variant flag and illegal flag.
//  Ports       : instruction - raw 32-bit instruction word (in)
//                bundle      - decoded fields, see decode_pkg::decoded_t (out)
//  Revision    : 1.0 - initial pipelined decode stage
// ============================================================================
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ENABLE_W = 1
) (
    input  logic [31:0] instruction,
    output decoded_t    bundle
);

    // W-variant groups only exist on RV64
    localparam bit c_en_w = (XLEN == 64) && (ENABLE_W != 0);

    logic [6:0]          w_opcode;
    logic [2:0]          w_fun3;
    logic [6:0]          w_fun7;
    logic [4:0]          w_rd;
    logic                w_sh_base;   // shift high bits select srl/sll
    logic                w_sh_alt;    // shift high bits select sra
    logic [IMM_W-1:0]    w_shamt;     // XLEN-wide shift amount, zero-extended
    logic [IMM_W-1:0]    w_shamt_w;   // 5-bit shift amount for W shifts
    logic [IMM_W-1:0]    w_imm_i;     // sign-extended I-immediate
    logic [OP_SEL_W-1:0] w_sel;
    logic                w_legal;
    logic                w_word;
    logic                w_use_imm;
    logic [IMM_W-1:0]    w_imm;

    assign w_opcode  = instruction[6:0];
    assign w_fun3    = instruction[14:12];
    assign w_fun7    = instruction[31:25];
    assign w_rd      = instruction[11:7];
    assign w_imm_i   = {{(IMM_W-12){instruction[31]}}, instruction[31:20]};
    assign w_shamt_w = {{(IMM_W-5){1'b0}}, instruction[24:20]};

    // RV64 shifts borrow instr[25] as shamt[5], so only six high bits are
    // checked; RV32 checks all seven.
    generate
        if (XLEN == 64) begin : g_shamt_rv64
            assign w_sh_base = (instruction[31:26] == 6'b000000);
            assign w_sh_alt  = (instruction[31:26] == 6'b010000);
            assign w_shamt   = {{(IMM_W-6){1'b0}}, instruction[25:20]};
        end else begin : g_shamt_rv32
            assign w_sh_base = (w_fun7 == FUN7_BASE);
            assign w_sh_alt  = (w_fun7 == FUN7_ALT);
            assign w_shamt   = {{(IMM_W-5){1'b0}}, instruction[24:20]};
        end
    endgenerate

    always_comb begin
        w_sel     = '0;
        w_legal   = 1'b0;
        w_word    = 1'b0;
        w_use_imm = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            OPC_OP: begin
                if (w_fun7 == FUN7_BASE) begin
                    w_sel   = base_sel(w_fun3);
                    w_legal = 1'b1;
                end else if (w_fun7 == FUN7_ALT) begin
                    if (w_fun3 == 3'b000) begin
                        w_sel[SEL_SUB] = 1'b1;
                        w_legal        = 1'b1;
                    end else if (w_fun3 == 3'b101) begin
                        w_sel[SEL_SRA] = 1'b1;
                        w_legal        = 1'b1;
                    end
                end
            end
            OPC_OP_IMM: begin
                w_use_imm = 1'b1;
                case (w_fun3)
                    3'b001: begin
                        if (w_sh_base) begin
                            w_sel[SEL_SLL] = 1'b1;
                            w_imm          = w_shamt;
                            w_legal        = 1'b1;
                        end
                    end
                    3'b101: begin
                        w_imm = w_shamt;
                        if (w_sh_base) begin
                            w_sel[SEL_SRL] = 1'b1;
                            w_legal        = 1'b1;
                        end else if (w_sh_alt) begin
                            w_sel[SEL_SRA] = 1'b1;
                            w_legal        = 1'b1;
                        end
                    end
                    default: begin
                        w_sel   = base_sel(w_fun3);
                        w_imm   = w_imm_i;
                        w_legal = 1'b1;
                    end
                endcase
            end
            OPC_OP_32: begin
                if (c_en_w) begin
                    w_word = 1'b1;
                    if (w_fun7 == FUN7_BASE) begin
                        case (w_fun3)
                            3'b000:  begin w_sel[SEL_ADD] = 1'b1; w_legal = 1'b1; end
                            3'b001:  begin w_sel[SEL_SLL] = 1'b1; w_legal = 1'b1; end
                            3'b101:  begin w_sel[SEL_SRL] = 1'b1; w_legal = 1'b1; end
                            default: ;
                        endcase
                    end else if (w_fun7 == FUN7_ALT) begin
                        case (w_fun3)
                            3'b000:  begin w_sel[SEL_SUB] = 1'b1; w_legal = 1'b1; end
                            3'b101:  begin w_sel[SEL_SRA] = 1'b1; w_legal = 1'b1; end
                            default: ;
                        endcase
                    end
                end
            end
            OPC_OP_IMM_32: begin
                if (c_en_w) begin
                    w_word    = 1'b1;
                    w_use_imm = 1'b1;
                    case (w_fun3)
                        3'b000: begin
                            w_sel[SEL_ADD] = 1'b1;
                            w_imm          = w_imm_i;
                            w_legal        = 1'b1;
                        end
                        3'b001: begin
                            w_imm = w_shamt_w;
                            if (w_fun7 == FUN7_BASE) begin
                                w_sel[SEL_SLL] = 1'b1;
                                w_legal        = 1'b1;
                            end
                        end
                        3'b101: begin
                            w_imm = w_shamt_w;
                            if (w_fun7 == FUN7_BASE) begin
                                w_sel[SEL_SRL] = 1'b1;
                                w_legal        = 1'b1;
                            end else if (w_fun7 == FUN7_ALT) begin
                                w_sel[SEL_SRA] = 1'b1;
                                w_legal        = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Control fields are forced to zero on anything not recognised. A
    // destination of x0 makes the word an architectural no-op: it never
    // writes and is never flagged illegal.
    always_comb begin
        bundle          = '0;
        bundle.rs1_addr = instruction[19:15];
        bundle.rs2_addr = instruction[24:20];
        bundle.rd_addr  = w_rd;
        bundle.opcode   = w_opcode;
        bundle.fun3     = w_fun3;
        bundle.fun7     = w_fun7;
        bundle.op_sel   = w_legal ? w_sel : '0;
        bundle.word_op  = w_legal & w_word;
        bundle.use_imm  = w_legal & w_use_imm;
        bundle.imm      = w_legal ? w_imm : '0;
        bundle.rf_we    = w_legal & (w_rd != 5'd0);
        bundle.illegal  = !w_legal & (w_rd != 5'd0);
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Pipelined integer decode stage. Wraps decode_logic with an
//                output register and a one-entry skid register (two entries
//                total) behind a valid/ready handshake, plus flush.
//  Ports       : clk, rst_n (sync, active low), flush
//                in_valid / in_ready / instruction      - fetch side
//                out_valid / out_ready                  - consumer side
//                rs1_addr, rs2_addr, rd_addr, opcode, fun3, fun7,
//                op_sel, word_op, use_imm, imm, rf_we, illegal - decoded bundle
//  Revision    : 1.0 - initial pipelined decode stage
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ENABLE_W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instruction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic [4:0]          rd_addr,
    output logic [6:0]          opcode,
    output logic [2:0]          fun3,
    output logic [6:0]          fun7,
    output logic [OP_SEL_W-1:0] op_sel,
    output logic                word_op,
    output logic                use_imm,
    output logic [XLEN-1:0]     imm,
    output logic                rf_we,
    output logic                illegal
);

    decoded_t w_dec;
    decoded_t r_out;
    decoded_t r_skid;
    logic     r_out_valid;
    logic     r_skid_valid;
    logic     w_in_xfer;
    logic     w_out_free;

    decode_logic #(
        .XLEN     (XLEN),
        .ENABLE_W (ENABLE_W)
    ) u_decode_logic (
        .instruction (instruction),
        .bundle      (w_dec)
    );

    // Ready depends only on skid occupancy, so out_ready never reaches
    // in_ready combinationally.
    assign in_ready   = !r_skid_valid;
    assign w_in_xfer  = in_valid & !r_skid_valid;
    // Output register can take new data this edge: empty or being consumed
    assign w_out_free = !r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // The skid entry is older than anything on the input, and while
            // it is occupied in_ready is low, so no input can arrive here.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            // Output held: park the incoming instruction in the skid entry
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign rs1_addr  = r_out.rs1_addr;
    assign rs2_addr  = r_out.rs2_addr;
    assign rd_addr   = r_out.rd_addr;
    assign opcode    = r_out.opcode;
    assign fun3      = r_out.fun3;
    assign fun7      = r_out.fun7;
    assign op_sel    = r_out.op_sel;
    assign word_op   = r_out.word_op;
    assign use_imm   = r_out.use_imm;
    assign imm       = r_out.imm[XLEN-1:0];
    assign rf_we     = r_out.rf_we;
    assign illegal   = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage. An RV64
//                instance carries the main stimulus; an RV32 instance fed
//                the same instructions covers the XLEN=32 encodings.
//  Revision    : 1.0 - initial bench
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;
    logic        out_ready32;

    logic        in_ready,  out_valid;
    logic [4:0]  rs1_addr,  rs2_addr,  rd_addr;
    logic [6:0]  opcode,    fun7;
    logic [2:0]  fun3;
    logic [9:0]  op_sel;
    logic        word_op,   use_imm,   rf_we,   illegal;
    logic [63:0] imm;

    logic        in_ready32, out_valid32;
    logic [4:0]  rs1_32, rs2_32, rd_32;
    logic [6:0]  opcode32, fun7_32;
    logic [2:0]  fun3_32;
    logic [9:0]  op_sel32;
    logic        word_op32, use_imm32, rf_we32, illegal32;
    logic [31:0] imm32;

    int n_cmp;
    int n_err;

    decode_stage #(.XLEN(64), .ENABLE_W(1)) u_dut64 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready), .instruction (instruction),
        .out_valid (out_valid), .out_ready (out_ready),
        .rs1_addr (rs1_addr), .rs2_addr (rs2_addr), .rd_addr (rd_addr),
        .opcode (opcode), .fun3 (fun3), .fun7 (fun7),
        .op_sel (op_sel), .word_op (word_op), .use_imm (use_imm),
        .imm (imm), .rf_we (rf_we), .illegal (illegal)
    );

    decode_stage #(.XLEN(32), .ENABLE_W(1)) u_dut32 (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready32), .instruction (instruction),
        .out_valid (out_valid32), .out_ready (out_ready32),
        .rs1_addr (rs1_32), .rs2_addr (rs2_32), .rd_addr (rd_32),
        .opcode (opcode32), .fun3 (fun3_32), .fun7 (fun7_32),
        .op_sel (op_sel32), .word_op (word_op32), .use_imm (use_imm32),
        .imm (imm32), .rf_we (rf_we32), .illegal (illegal32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bb_instr [4] = '{32'h00b50c33, 32'h40b50c33, 32'h00b51c33, 32'h00b52c33};
    logic [9:0]  bb_sel   [4] = '{10'h001, 10'h002, 10'h004, 10'h008};

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        out_ready   = 1'b1;
        out_ready32 = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready",  in_ready,  1);
        check_val("rst_op_sel",    op_sel,    0);
        check_val("rst_imm",       imm,       0);
        check_val("rst_opcode",    opcode,    0);

        // Back-to-back R-type, one cycle latency
        for (int i = 0; i < 4; i++) begin
            instruction = bb_instr[i];
            in_valid    = 1'b1;
            step();
            check_val($sformatf("bb%0d_valid", i),   out_valid, 1);
            check_val($sformatf("bb%0d_rs1", i),     rs1_addr,  10);
            check_val($sformatf("bb%0d_rs2", i),     rs2_addr,  11);
            check_val($sformatf("bb%0d_rd", i),      rd_addr,   24);
            check_val($sformatf("bb%0d_op_sel", i),  op_sel,    bb_sel[i]);
            check_val($sformatf("bb%0d_rf_we", i),   rf_we,     1);
            check_val($sformatf("bb%0d_illegal", i), illegal,   0);
        end
        in_valid = 1'b0;
        step();
        check_val("bb_drain_valid", out_valid, 0);

        // addi x1,x2,-1
        instruction = 32'hfff10093;
        in_valid    = 1'b1;
        step();
        check_val("addi_use_imm", use_imm, 1);
        check_val("addi_imm",     imm,     64'hFFFF_FFFF_FFFF_FFFF);
        check_val("addi_op_sel",  op_sel,  10'h001);
        check_val("addi_rd",      rd_addr, 1);
        check_val("addi_rs1",     rs1_addr, 2);
        check_val("addi32_imm",   imm32,   32'hFFFF_FFFF);

        // srai x11,x10,63: legal on RV64, shamt too wide for RV32
        instruction = 32'h43f55593;
        step();
        check_val("srai_op_sel",   op_sel,    10'h080);
        check_val("srai_imm",      imm,       63);
        check_val("srai_rd",       rd_addr,   11);
        check_val("srai_illegal",  illegal,   0);
        check_val("srai32_illegal", illegal32, 1);
        check_val("srai32_op_sel", op_sel32,  0);

        // subw: W variant on RV64, illegal on RV32
        instruction = 32'h40b50c3b;
        step();
        check_val("subw_op_sel",    op_sel,    10'h002);
        check_val("subw_word_op",   word_op,   1);
        check_val("subw_rf_we",     rf_we,     1);
        check_val("subw32_illegal", illegal32, 1);
        check_val("subw32_op_sel",  op_sel32,  0);
        check_val("subw32_rf_we",   rf_we32,   0);
        check_val("subw32_fun7",    fun7_32,   7'h20);

        // add x0: no write, not illegal
        instruction = 32'h00b50033;
        step();
        check_val("addx0_rf_we",   rf_we,   0);
        check_val("addx0_illegal", illegal, 0);
        check_val("addx0_op_sel",  op_sel,  10'h001);
        in_valid = 1'b0;
        step();

        // Backpressure: A, B accepted, C refused until the skid frees
        out_ready   = 1'b0;
        instruction = 32'h00b500b3;   // add x1
        in_valid    = 1'b1;
        step();
        check_val("bp_a_valid", out_valid, 1);
        check_val("bp_a_rd",    rd_addr,   1);
        check_val("bp_a_ready", in_ready,  1);
        instruction = 32'h00b50133;   // add x2
        step();
        check_val("bp_b_ready", in_ready, 0);
        check_val("bp_b_rd",    rd_addr,  1);
        instruction = 32'h00b501b3;   // add x3
        step();
        check_val("bp_c_ready", in_ready,  0);
        check_val("bp_hold_rd", rd_addr,   1);
        check_val("bp_hold_v",  out_valid, 1);
        out_ready = 1'b1;
        step();
        check_val("bp_rel_rd",    rd_addr,   2);
        check_val("bp_rel_valid", out_valid, 1);
        check_val("bp_rel_ready", in_ready,  1);
        step();
        check_val("bp_c_rd",    rd_addr,   3);
        check_val("bp_c_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        check_val("bp_end_valid", out_valid, 0);

        // Flush with both entries full and input pending
        out_ready   = 1'b0;
        instruction = 32'h00b50233;   // add x4
        in_valid    = 1'b1;
        step();
        instruction = 32'h00b502b3;   // add x5
        step();
        check_val("fl_full_ready", in_ready, 0);
        instruction = 32'h00b50333;   // add x6
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_valid", out_valid, 0);
        check_val("fl_ready", in_ready,  1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("fl_after%0d_valid", i), out_valid, 0);
        end

        // Flush discards an instruction transferring in the same cycle
        instruction = 32'h00b503b3;   // add x7
        in_valid    = 1'b1;
        flush       = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("fl_xfer_valid", out_valid, 0);
        step();
        check_val("fl_xfer_valid2", out_valid, 0);

        // Reset mid-stream
        instruction = 32'hfff10093;
        in_valid    = 1'b1;
        step();
        check_val("mid_pre_valid", out_valid, 1);
        instruction = 32'h43f55593;
        rst_n       = 1'b0;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_rd",    rd_addr,   0);
        check_val("mid_rst_rs1",   rs1_addr,  0);
        check_val("mid_rst_imm",   imm,       0);
        check_val("mid_rst_sel",   op_sel,    0);
        check_val("mid_rst_useim", use_imm,   0);
        check_val("mid_rst_ready", in_ready,  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
